// File: rtl/hazard_pipe_tracker_pkg.sv
// hazard_pipe_tracker_pkg: shared pipeline constants, FSM encoding and load-opcode helper.
package hazard_pipe_tracker_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Bubble is all-zero in every field; sliced down to the tag width by users.
    localparam logic [63:0] BUBBLE_TAG = '0;

    localparam int unsigned OP_LW   = 6;
    localparam int unsigned OP_LOAD = 8;

    function automatic logic is_load_op(input int unsigned op);
        return (op == OP_LW) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/hazard_pipe_tracker_tag_stage_reg.sv
// tag_stage_reg: one pipeline tag register with async active-low reset to bubble.
module tag_stage_reg #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    import hazard_pipe_tracker_pkg::*;

    logic [W-1:0] tag_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tag_q <= BUBBLE_TAG[W-1:0];
        else        tag_q <= d_i;
    end

    assign q_o = tag_q;

endmodule

// File: rtl/hazard_pipe_tracker.sv
// hazard_pipe_tracker: EX/MEM/WB destination-tag pipe with flush FSM, stall holds
// and saturating stall/flush event counters.
module hazard_pipe_tracker #(
    parameter int REG_W = 4,
    parameter int OP_W  = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [REG_W-1:0] dec_rd,
    input  logic             dec_rw,
    input  logic [OP_W-1:0]  dec_op,
    input  logic             stall_in,
    input  logic             flush,
    input  logic             cnt_clr,
    output logic [REG_W-1:0] rd2,
    output logic [REG_W-1:0] rd3,
    output logic [REG_W-1:0] rd4,
    output logic             rw2,
    output logic             rw3,
    output logic             rw4,
    output logic [OP_W-1:0]  op2,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             flush_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import hazard_pipe_tracker_pkg::*;

    localparam int TW = REG_W + 1 + OP_W;
    localparam int RW = REG_W + 1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic [TW-1:0]    new_tag, s2;
    logic [RW-1:0]    s3, s4;
    logic             busy, hold, squash;

    // Holds are gated by rst_n so they read 0 while reset is asserted.
    always_comb begin
        busy        = state_q == ST_FLUSH;
        hold        = rst_n & stall_in & ~flush & ~busy;
        squash      = stall_in | flush | busy;
        new_tag     = squash ? BUBBLE_TAG[TW-1:0] : {dec_rd, dec_rw & dec_valid, dec_op};
        state_d     = flush ? ST_FLUSH : ST_RUN;
        stall_cnt_d = cnt_clr ? '0 : (hold && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
        flush_cnt_d = cnt_clr ? '0 : (flush && !(&flush_cnt_q)) ? flush_cnt_q + 1'b1 : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Only EX needs the opcode; MEM and WB carry just {rd, rw}.
    tag_stage_reg #(.W(TW)) u_stage2 (.clk(clk), .rst_n(rst_n), .d_i(new_tag),        .q_o(s2));
    tag_stage_reg #(.W(RW)) u_stage3 (.clk(clk), .rst_n(rst_n), .d_i(s2[TW-1:OP_W]),  .q_o(s3));
    tag_stage_reg #(.W(RW)) u_stage4 (.clk(clk), .rst_n(rst_n), .d_i(s3),             .q_o(s4));

    assign {rd2, rw2, op2} = s2;
    assign {rd3, rw3}      = s3;
    assign {rd4, rw4}      = s4;
    assign pc_hold         = hold;
    assign ifid_hold       = hold;
    assign flush_busy      = busy;
    assign stall_cnt       = stall_cnt_q;
    assign flush_cnt       = flush_cnt_q;

endmodule

// File: tb/tb_hazard_pipe_tracker.sv
// tb_hazard_pipe_tracker: directed and random stimulus against a stage-list reference model.
module tb_hazard_pipe_tracker;
    localparam int REG_W = 4;
    localparam int OP_W  = 6;
    localparam int CNT_W = 4;
    localparam int CAP   = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             dec_valid, dec_rw, stall_in, flush, cnt_clr;
    logic [REG_W-1:0] dec_rd;
    logic [OP_W-1:0]  dec_op;
    logic [REG_W-1:0] rd2, rd3, rd4;
    logic             rw2, rw3, rw4, pc_hold, ifid_hold, flush_busy;
    logic [OP_W-1:0]  op2;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_pipe_tracker #(.REG_W(REG_W), .OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_rd(dec_rd), .dec_rw(dec_rw),
        .dec_op(dec_op), .stall_in(stall_in), .flush(flush), .cnt_clr(cnt_clr),
        .rd2(rd2), .rd3(rd3), .rd4(rd4), .rw2(rw2), .rw3(rw3), .rw4(rw4), .op2(op2),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .flush_busy(flush_busy),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: list of in-flight tags indexed by stage, a flushing flag, integer counters.
    int  m_rd[2:4];
    int  m_rw[2:4];
    int  m_op2;
    bit  m_fl;
    int  m_sc, m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int s = 2; s <= 4; s++) begin m_rd[s] = 0; m_rw[s] = 0; end
        m_op2 = 0; m_fl = 0; m_sc = 0; m_fc = 0;
    endtask

    task automatic chk_all(input string t);
        chk({t, "_rd2"}, 32'(rd2), 32'(m_rd[2]));
        chk({t, "_rd3"}, 32'(rd3), 32'(m_rd[3]));
        chk({t, "_rd4"}, 32'(rd4), 32'(m_rd[4]));
        chk({t, "_rw2"}, 32'(rw2), 32'(m_rw[2]));
        chk({t, "_rw3"}, 32'(rw3), 32'(m_rw[3]));
        chk({t, "_rw4"}, 32'(rw4), 32'(m_rw[4]));
        chk({t, "_op2"}, 32'(op2), 32'(m_op2));
        chk({t, "_busy"}, 32'(flush_busy), 32'(m_fl));
        chk({t, "_scnt"}, 32'(stall_cnt), 32'(m_sc));
        chk({t, "_fcnt"}, 32'(flush_cnt), 32'(m_fc));
    endtask

    // Called at a negedge: drive, check holds, clock, advance model, check at next negedge.
    task automatic step(input string t, input bit v, input int rd, input bit rw, input int op,
                        input bit st, input bit fl, input bit clr);
        bit exp_hold, bubble;
        dec_valid = v; dec_rd = REG_W'(rd); dec_rw = rw; dec_op = OP_W'(op);
        stall_in = st; flush = fl; cnt_clr = clr;
        #1;
        exp_hold = st && !fl && !m_fl;
        bubble   = st || fl || m_fl;
        chk({t, "_pc_hold"}, 32'(pc_hold), 32'(exp_hold));
        chk({t, "_ifid_hold"}, 32'(ifid_hold), 32'(exp_hold));
        @(posedge clk);
        m_rd[4] = m_rd[3]; m_rw[4] = m_rw[3];
        m_rd[3] = m_rd[2]; m_rw[3] = m_rw[2];
        m_rd[2] = bubble ? 0 : rd;
        m_rw[2] = bubble ? 0 : int'(v && rw);
        m_op2   = bubble ? 0 : op;
        m_fl    = fl;
        m_sc    = clr ? 0 : (exp_hold && m_sc < CAP) ? m_sc + 1 : m_sc;
        m_fc    = clr ? 0 : (fl && m_fc < CAP) ? m_fc + 1 : m_fc;
        @(negedge clk);
        chk_all(t);
    endtask

    task automatic idle(input string t);
        step(t, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0; dec_valid = 0; dec_rd = 0; dec_rw = 0; dec_op = 0;
        stall_in = 1; flush = 0; cnt_clr = 0;
        m_reset();
        #12;
        chk_all("reset");
        chk("reset_pc_hold", 32'(pc_hold), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Single instruction walks EX, MEM, WB then drains.
        step("r037a", 1, 5, 1, 0, 0, 0, 0);
        chk("r037_rd2", 32'(rd2), 32'd5);
        idle("r037b");
        chk("r037_rd3", 32'(rd3), 32'd5);
        idle("r037c");
        chk("r037_rd4", 32'(rd4), 32'd5);
        idle("r037d");
        chk("r037_rw4", 32'(rw4), 32'd0);

        // Load in EX then load-use stall.
        step("r038a", 1, 3, 1, 6, 0, 0, 0);
        step("r038b", 1, 7, 1, 1, 1, 0, 0);
        chk("r038_rw2", 32'(rw2), 32'd0);
        chk("r038_rd3", 32'(rd3), 32'd3);
        chk("r038_scnt", 32'(stall_cnt), 32'd1);

        // Flush while valid writers are decoded: two bubbles.
        step("r039a", 1, 9, 1, 2, 0, 0, 0);
        step("r039b", 1, 10, 1, 2, 0, 1, 0);
        chk("r039_busy", 32'(flush_busy), 32'd1);
        step("r039c", 1, 11, 1, 2, 0, 0, 0);
        chk("r039_busy_off", 32'(flush_busy), 32'd0);
        step("r039d", 1, 12, 1, 2, 1, 0, 0);
        step("r039e", 1, 13, 1, 2, 0, 0, 0);
        chk("r039_rd2", 32'(rd2), 32'd13);

        // Flush beats stall.
        step("r040", 1, 4, 1, 3, 1, 1, 0);
        idle("r040b");

        // Saturation and clear-priority.
        step("r041clr", 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < CAP + 1; i++) step("r041fill", 0, 0, 0, 0, 1, 0, 0);
        chk("r041_sat", 32'(stall_cnt), 32'(CAP));
        step("r041more", 0, 0, 0, 0, 1, 0, 0);
        chk("r041_sat2", 32'(stall_cnt), 32'(CAP));
        step("r041clr2", 0, 0, 0, 0, 1, 0, 1);
        chk("r041_zero", 32'(stall_cnt), 32'd0);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0,
                 $urandom_range(0, 30) == 0);

        // Reset asserted mid-FLUSH with writers in flight.
        step("r042a", 1, 1, 1, 0, 0, 0, 0);
        step("r042b", 1, 1, 1, 0, 0, 0, 0);
        step("r042c", 1, 1, 1, 0, 0, 1, 0);
        stall_in = 1;
        #2;
        rst_n = 0;
        m_reset();
        #1;
        chk_all("r042rst");
        chk("r042_hold", 32'(pc_hold), 32'd0);
        @(negedge clk);
        rst_n = 1;
        step("r042d", 1, 2, 1, 0, 0, 0, 0);
        chk("r042_rd2", 32'(rd2), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
